// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the CPU datapath and the hazard/sequencing block.
// The datapath side (master) reports what the ID and EX instructions do and
// raises halt requests; the controller side (slave) returns the fetch address,
// pipeline-register enables/flushes and per-stage valid bits.
interface pipeline_hazard_ctrl_if #(
    parameter int PC_WIDTH = 10
);
    // Datapath -> controller
    logic                id_reads_a;
    logic                id_reads_b;
    logic                id_jump;
    logic [PC_WIDTH-1:0] id_jump_target;
    logic                ex_mem_read;
    logic                ex_writes_a;
    logic                ex_writes_b;
    logic                ex_branch_taken;
    logic [PC_WIDTH-1:0] ex_branch_target;
    logic                halt_req;

    // Controller -> datapath
    logic [PC_WIDTH-1:0] pc;
    logic                pc_en;
    logic                if_id_en;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic                stall;
    logic                valid_id;
    logic                valid_ex;
    logic                valid_mem;
    logic                valid_wb;
    logic                halted;

    modport master (
        output id_reads_a, id_reads_b, id_jump, id_jump_target,
               ex_mem_read, ex_writes_a, ex_writes_b,
               ex_branch_taken, ex_branch_target, halt_req,
        input  pc, pc_en, if_id_en, if_id_flush, id_ex_flush, stall,
               valid_id, valid_ex, valid_mem, valid_wb, halted
    );

    modport slave (
        input  id_reads_a, id_reads_b, id_jump, id_jump_target,
               ex_mem_read, ex_writes_a, ex_writes_b,
               ex_branch_taken, ex_branch_target, halt_req,
        output pc, pc_en, if_id_en, if_id_flush, id_ex_flush, stall,
               valid_id, valid_ex, valid_mem, valid_wb, halted
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing block of the 5-stage CPU. Owns the program counter,
// decides stalls (load-use), redirects (ID jump, EX taken branch) and the
// halt/drain sequence, and tracks which stages hold real instructions so
// MEM/WB can gate their side effects.
module pipeline_hazard_ctrl #(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic                halted_q;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                validId_q, validId_d;
    logic                validEx_q, validEx_d;
    logic                validMem_q, validMem_d;
    logic                validWb_q, validWb_d;

    logic fetchOk;
    logic br;
    logic jp;
    logic hz;
    logic depHit;
    logic drainDone;

    // Qualify the raw datapath events with stage validity; a branch outranks everything.
    always_comb begin
        fetchOk = (state_q == RUN);
        br      = bus.ex_branch_taken & validEx_q;
        jp      = bus.id_jump & validId_q & ~br;
        depHit  = (bus.id_reads_a & bus.ex_writes_a) | (bus.id_reads_b & bus.ex_writes_b);
        hz      = validId_q & validEx_q & bus.ex_mem_read & depHit & ~br;
    end

    // Next fetch address: only redirected or advanced while fetching is enabled.
    always_comb begin
        pc_d = pc_q;
        if (fetchOk) begin
            if (br) begin
                pc_d = bus.ex_branch_target;
            end else if (hz) begin
                pc_d = pc_q;
            end else if (jp) begin
                pc_d = bus.id_jump_target;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    // Valid bits shift down the pipe; bubbles enter on stall, flush or disabled fetch.
    always_comb begin
        validWb_d  = validMem_q;
        validMem_d = validEx_q;
        validEx_d  = validId_q & ~hz & ~br;
        if (hz) begin
            validId_d = validId_q;
        end else begin
            validId_d = fetchOk & ~br & ~jp;
        end
        drainDone = ~(validId_d | validEx_d | validMem_d | validWb_d);
    end

    // PC and per-stage valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            validId_q  <= 1'b0;
            validEx_q  <= 1'b0;
            validMem_q <= 1'b0;
            validWb_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            validId_q  <= validId_d;
            validEx_q  <= validEx_d;
            validMem_q <= validMem_d;
            validWb_q  <= validWb_d;
        end
    end

    // Run/drain/halt sequencer with a registered halted flag; only reset leaves HALTED.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    halted_q <= 1'b0;
                    if (bus.halt_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stall       = hz;
    assign bus.pc_en       = (fetchOk & ~hz) | br;
    assign bus.if_id_en    = ~hz;
    assign bus.if_id_flush = br | jp | ~fetchOk;
    assign bus.id_ex_flush = hz | br;
    assign bus.valid_id    = validId_q;
    assign bus.valid_ex    = validEx_q;
    assign bus.valid_mem   = validMem_q;
    assign bus.valid_wb    = validWb_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. A reference model tracks which instruction
// address sits in each stage (-1 for a bubble) plus the fetch PC and run mode,
// and every negative clock edge the DUT outputs are compared against it.
// Directed scenarios add hand-computed literal expectations on top.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if #(.PC_WIDTH(10)) bus ();

    pipeline_hazard_ctrl #(
        .PC_WIDTH(10),
        .RESET_PC(10'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: address held by ID, EX, MEM, WB (-1 = bubble).
    int stageAddr [4];
    int mPc;
    int mMode;     // 0 fetching, 1 draining, 2 halted

    logic eRun, eBr, eHz, eJp;
    int   eNextId, eNextEx;
    logic eDrained;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: which events fire this cycle and what each stage holds next.
    always_comb begin
        eRun = (mMode == 0);
        eBr  = bus.ex_branch_taken && (stageAddr[1] >= 0);
        eHz  = (stageAddr[0] >= 0) && (stageAddr[1] >= 0) && bus.ex_mem_read &&
               ((bus.id_reads_a && bus.ex_writes_a) || (bus.id_reads_b && bus.ex_writes_b)) && !eBr;
        eJp  = bus.id_jump && (stageAddr[0] >= 0) && !eBr;
        eNextEx = (eHz || eBr) ? -1 : stageAddr[0];
        if (eHz) eNextId = stageAddr[0];
        else if (eRun && !eBr && !eJp) eNextId = mPc;
        else eNextId = -1;
        eDrained = (eNextId < 0) && (eNextEx < 0) && (stageAddr[1] < 0) && (stageAddr[2] < 0);
    end

    // Model: advance the pipeline contents, fetch PC and run mode each clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) stageAddr[i] <= -1;
            mPc   <= 0;
            mMode <= 0;
        end else begin
            stageAddr[3] <= stageAddr[2];
            stageAddr[2] <= stageAddr[1];
            stageAddr[1] <= eNextEx;
            stageAddr[0] <= eNextId;
            if (eRun) begin
                if (eBr) mPc <= int'(bus.ex_branch_target);
                else if (eJp && !eHz) mPc <= int'(bus.id_jump_target);
                else if (!eHz) mPc <= (mPc + 1) % 1024;
            end
            if (mMode == 0 && bus.halt_req) mMode <= 1;
            else if (mMode == 1 && eDrained) mMode <= 2;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle: compare the DUT against the model away from the rising edge.
    always @(negedge clk) begin
        checkOutput("model_pc", {22'd0, bus.pc}, mPc);
        checkOutput("model_ctrl",
            {22'd0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.stall,
             bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb, bus.halted},
            {22'd0, (eRun && !eHz) || eBr, !eHz, eBr || eJp || !eRun, eHz || eBr, eHz,
             stageAddr[0] >= 0, stageAddr[1] >= 0, stageAddr[2] >= 0, stageAddr[3] >= 0,
             mMode == 2});
    end

    task automatic applyStimulus(input logic ra, input logic rb, input logic jmp, input logic [9:0] jt,
                                 input logic memRd, input logic wa, input logic wb,
                                 input logic bt, input logic [9:0] btgt, input logic halt);
        bus.id_reads_a       = ra;
        bus.id_reads_b       = rb;
        bus.id_jump          = jmp;
        bus.id_jump_target   = jt;
        bus.ex_mem_read      = memRd;
        bus.ex_writes_a      = wa;
        bus.ex_writes_b      = wb;
        bus.ex_branch_taken  = bt;
        bus.ex_branch_target = btgt;
        bus.halt_req         = halt;
    endtask

    task automatic clearInputs();
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 0, 0, 10'd0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValids(input string name, input logic [3:0] expected);
        checkOutput(name, {28'd0, bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, {28'd0, expected});
    endtask

    initial begin
        logic [9:0] frozenPc;
        int waited;

        reset = 1'b0;
        clearInputs();
        #7;
        // Reset values
        checkOutput("rst_pc", {22'd0, bus.pc}, 32'h0);
        checkValids("rst_valid", 4'b0000);
        checkOutput("rst_halted", {31'd0, bus.halted}, 32'd0);
        checkOutput("rst_ctrl", {27'd0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.stall},
                    {27'd0, 5'b11000});
        #1 reset = 1'b1;
        #1 checkOutput("first_pc", {22'd0, bus.pc}, 32'd0);

        // Free run: pc 1,2,3,4 and WB valid after the fourth edge
        tick(); checkOutput("run_pc1", {22'd0, bus.pc}, 32'd1); checkValids("run_v1", 4'b1000);
        tick(); checkOutput("run_pc2", {22'd0, bus.pc}, 32'd2);
        tick(); checkOutput("run_pc3", {22'd0, bus.pc}, 32'd3); checkValids("run_v3", 4'b1110);
        tick(); checkOutput("run_pc4", {22'd0, bus.pc}, 32'd4); checkValids("run_v4", 4'b1111);
        tick(); checkOutput("run_pc5", {22'd0, bus.pc}, 32'd5);

        // Load-use on register A at pc 5
        applyStimulus(1, 0, 0, 10'd0, 1, 1, 0, 0, 10'd0, 0);
        #1 checkOutput("lu_a_stall", {29'd0, bus.stall, bus.pc_en, bus.id_ex_flush}, {29'd0, 3'b101});
        tick(); clearInputs();
        #1 checkOutput("lu_a_hold", {22'd0, bus.pc}, 32'd5);
        checkValids("lu_a_bubble", 4'b1011);
        checkOutput("lu_a_once", {31'd0, bus.stall}, 32'd0);
        tick(); checkOutput("lu_a_next", {22'd0, bus.pc}, 32'd6);

        // Load-use on register B only
        applyStimulus(0, 1, 0, 10'd0, 1, 0, 1, 0, 10'd0, 0);
        #1 checkOutput("lu_b_stall", {31'd0, bus.stall}, 32'd1);
        tick(); clearInputs();
        #1 checkOutput("lu_b_hold", {22'd0, bus.pc}, 32'd6);
        tick(); checkOutput("lu_b_next", {22'd0, bus.pc}, 32'd7);

        // A written, B read: no dependency
        applyStimulus(0, 1, 0, 10'd0, 1, 1, 0, 0, 10'd0, 0);
        #1 checkOutput("lu_ab_nostall", {30'd0, bus.stall, bus.pc_en}, {30'd0, 2'b01});
        tick(); clearInputs();
        #1 checkOutput("lu_ab_pc", {22'd0, bus.pc}, 32'd8);

        // Jump at pc 8 to 0x120
        applyStimulus(0, 0, 1, 10'h120, 0, 0, 0, 0, 10'd0, 0);
        #1 checkOutput("jmp_flush", {29'd0, bus.if_id_flush, bus.pc_en, bus.stall}, {29'd0, 3'b110});
        tick(); clearInputs();
        #1 checkOutput("jmp_pc", {22'd0, bus.pc}, 32'h120);
        checkOutput("jmp_slot", {31'd0, bus.valid_id}, 32'd0);
        tick(); checkOutput("jmp_pc2", {22'd0, bus.pc}, 32'h121); checkValids("jmp_one_slot", 4'b1011);
        tick();

        // Branch and jump together with a hazard pattern: branch wins
        applyStimulus(1, 0, 1, 10'h200, 1, 1, 0, 1, 10'h040, 0);
        #1 checkOutput("brj_ctrl", {28'd0, bus.stall, bus.id_ex_flush, bus.if_id_flush, bus.pc_en},
                       {28'd0, 4'b0111});
        tick(); clearInputs();
        #1 checkOutput("brj_pc", {22'd0, bus.pc}, 32'h040);
        checkOutput("brj_valid", {30'd0, bus.valid_id, bus.valid_ex}, 32'd0);

        // Refill, then pulse halt
        repeat (4) tick();
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 0, 0, 10'd0, 1);
        tick(); clearInputs();
        #1 frozenPc = bus.pc;
        waited = 0;
        while (!bus.halted && waited < 10) begin
            tick();
            waited++;
            checkOutput("drain_pc_frozen", {22'd0, bus.pc}, {22'd0, frozenPc});
        end
        checkOutput("drain_cycles", waited, 32'd4);
        checkOutput("halted_set", {31'd0, bus.halted}, 32'd1);
        checkValids("halted_valid", 4'b0000);
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 0, 0, 10'd0, 1);
        repeat (2) tick();
        clearInputs();
        repeat (2) tick();
        checkOutput("halted_stays", {21'd0, bus.halted, bus.pc}, {21'd0, 1'b1, frozenPc});

        // Reset out of HALTED, run again, reset asynchronously in DRAIN
        reset = 1'b0;
        #1 checkOutput("rst_halt_clear", {31'd0, bus.halted}, 32'd0);
        #1 reset = 1'b1;
        repeat (6) tick();
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 0, 0, 10'd0, 1);
        tick(); clearInputs();
        tick();
        checkValids("drain_busy", 4'b0111);
        reset = 1'b0;
        #1 checkOutput("rst_drain_pc", {22'd0, bus.pc}, 32'd0);
        checkValids("rst_drain_valid", 4'b0000);
        checkOutput("rst_drain_ctrl", {29'd0, bus.halted, bus.pc_en, bus.if_id_flush}, {29'd0, 3'b010});
        #1 reset = 1'b1;

        // Asynchronous reset in mid-stall
        repeat (5) tick();
        applyStimulus(1, 0, 0, 10'd0, 1, 1, 0, 0, 10'd0, 0);
        #1 checkOutput("mid_stall_on", {31'd0, bus.stall}, 32'd1);
        reset = 1'b0;
        #1 checkOutput("rst_stall_pc", {22'd0, bus.pc}, 32'd0);
        checkValids("rst_stall_valid", 4'b0000);
        checkOutput("rst_stall_off", {31'd0, bus.stall}, 32'd0);
        clearInputs();
        #1 reset = 1'b1;

        // Free run across the PC wrap
        waited = 0;
        while (bus.pc != 10'h3FF && waited < 1100) begin
            tick();
            waited++;
        end
        checkOutput("wrap_reached", {31'd0, bus.pc == 10'h3FF}, 32'd1);
        tick();
        checkOutput("wrap_pc", {22'd0, bus.pc}, 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing block for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It owns the 10-bit program counter and produces the enable and flush controls for the IF/ID and ID/EX pipeline registers. It tracks a valid bit per stage so the MEM and WB stages can gate memory and register writes. It resolves load-use stalls, ID-stage jumps, EX-stage taken branches and a halt/drain sequence.

## Interface
Parameters:
- PC_WIDTH, 10, width of the program counter and of the jump/branch targets
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately while low
- id_reads_a  in  1  instruction in ID reads register A
- id_reads_b  in  1  instruction in ID reads register B
- id_jump  in  1  instruction in ID is an unconditional jump
- id_jump_target  in  PC_WIDTH  jump destination
- ex_mem_read  in  1  instruction in EX is a data-memory load
- ex_writes_a  in  1  instruction in EX writes register A
- ex_writes_b  in  1  instruction in EX writes register B
- ex_branch_taken  in  1  branch in EX resolved as taken
- ex_branch_target  in  PC_WIDTH  branch destination
- halt_req  in  1  level request to stop fetching and drain
- pc  out  PC_WIDTH  fetch address for the instruction ROM
- pc_en  out  1  PC advances or is redirected this cycle
- if_id_en  out  1  IF/ID register captures this cycle
- if_id_flush  out  1  IF/ID register loads a bubble this cycle
- id_ex_flush  out  1  ID/EX register loads a bubble this cycle
- stall  out  1  load-use stall is active this cycle
- valid_id, valid_ex, valid_mem, valid_wb  out  1 each  the stage holds a real instruction
- halted  out  1  pipeline is fully drained and stopped

## Operation
- Qualified events, evaluated combinationally each cycle:
  - br = ex_branch_taken & valid_ex
  - jp = id_jump & valid_id & !br
  - hz = valid_id & valid_ex & ex_mem_read & ((id_reads_a & ex_writes_a) | (id_reads_b & ex_writes_b)) & !br
- Priority: br > hz > jp > sequential fetch. A jump that is stalled by a hazard is taken on the cycle after the stall.
- PC next-value rules:
  - br: pc <= ex_branch_target
  - hz: pc holds
  - jp: pc <= id_jump_target
  - otherwise: pc <= pc + 1, wrapping from 2^PC_WIDTH-1 to 0
  - The PC also holds in the DRAIN and HALTED states.
- Valid-bit next-value rules:
  - valid_wb <= valid_mem
  - valid_mem <= valid_ex
  - valid_ex <= valid_id & !hz & !br
  - valid_id <= fetch_ok & !br & !jp, where fetch_ok = (state == RUN)
  - On hz, valid_id holds.
- Combinational outputs:
  - stall = hz
  - pc_en = fetch_ok & !hz, or br
  - if_id_en = !hz
  - if_id_flush = br | jp | !fetch_ok
  - id_ex_flush = hz | br
- State machine, 3 states:
  - RUN: moves to DRAIN when halt_req = 1.
  - DRAIN: fetch is disabled, but stalls and branches are still processed. A taken branch in DRAIN does not redirect the PC. Moves to HALTED when valid_id, valid_ex, valid_mem and valid_wb are all 0 (evaluated on the next-state values).
  - HALTED: halted = 1, all valid bits = 0, PC frozen. The only exit is reset. halt_req has no effect once the state leaves RUN.
- Reset values:
  - pc = RESET_PC
  - all valid bits = 0
  - state = RUN, halted = 0
  - The combinational outputs follow these values: stall = 0, pc_en = 1, if_id_en = 1, if_id_flush = 0, id_ex_flush = 0.

## Timing
- pc, valid bits, state and halted are registered. stall, pc_en, if_id_en and both flush outputs are combinational from the current-cycle inputs and registers, and are valid before the same rising edge.
- First fetch: pc = RESET_PC in the first cycle after reset deasserts. valid_id = 1 after the first edge, and valid_wb = 1 after the fourth edge.
- Penalties:
  - load-use: 1 bubble
  - jump: 1 squashed slot
  - taken branch: 2 squashed slots (the IF and ID instructions)
- Reset asserted in mid-operation (stall, drain or branch) forces the reset values asynchronously. No partial update completes.
- A branch and a hazard in the same cycle: the branch wins, the PC is redirected and no stall is counted.

## Test plan
- Reset then free-run with no events: pc goes 0,1,2,3. valid_wb first reads 1 in cycle 4. Run 1030 cycles and confirm pc wraps from 0x3FF to 0x000.
- Load-use: ex_mem_read = 1, ex_writes_a = 1, id_reads_a = 1, with both stages valid at pc = 5. Required: stall = 1 for exactly 1 cycle, pc holds at 5, valid_ex = 0 on the next cycle, and pc = 6 on the cycle after that. Repeat with a B-only dependency (stall) and an A-write/B-read pair (no stall).
- Jump: id_jump = 1, id_jump_target = 0x120 at pc = 8. Required: pc = 0x120 on the next cycle, if_id_flush = 1, exactly 1 invalid slot in ID.
- Branch and jump together: ex_branch_taken = 1, target 0x040, plus id_jump = 1, target 0x200. Required: pc = 0x040, valid_id = 0, valid_ex = 0, jump ignored.
- Halt: pulse halt_req in RUN. Required: no further fetches, pc frozen, halted = 1 exactly once all 4 valid bits are 0 (within 4 cycles without a stall). A later halt_req = 0 does not restart the pipeline.
- Asynchronous reset in mid-stall and in DRAIN: pc returns to RESET_PC and the valid bits clear without waiting for a clock edge. halted = 0.
